// File: rtl/stream_frame_gate.sv
// Purpose : frame-aligned gate and geometry checker for a raw fval/lval/pixel sensor stream.
// Latency : 2 clk from i_fval/i_lval/iv_pix_data to o_fval/o_lval/ov_pix_data, constant.
// Backpres: none; the sensor stream cannot stall, so every cycle is accepted and registered.
//
// Ports:
//   clk, reset_n        pixel clock, synchronous active-low reset
//   i_stream_enable     level request to pass whole frames
//   i_fval/i_lval/iv_pix_data      raw stream in
//   o_fval/o_lval/ov_pix_data      gated stream out (lval only inside fval, data zero outside lval)
//   o_frame_done        one-cycle pulse on the first o_fval=0 cycle after a passed frame
//   ov_frame_width/ov_frame_height/o_line_err   geometry of the last passed frame
module stream_frame_gate #(
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNEL_NUM = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_stream_enable,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic [CNT_WIDTH-1:0]              ov_frame_width,
  output logic [CNT_WIDTH-1:0]              ov_frame_height,
  output logic                              o_line_err
);

  localparam int DW = DATA_WIDTH * CHANNEL_NUM;

  typedef enum logic {ST_OFF, ST_ON} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // input pipeline
  logic          d1_fval_q, d1_fval_d, d1_lval_q, d1_lval_d, d2_fval_q, d2_fval_d;
  logic [DW-1:0] d1_data_q, d1_data_d;
  // d1_vld/d2_vld mark stages holding a real sample since reset, so the
  // zeroed post-reset history cannot fake a rise in the middle of a frame
  logic          d1_vld_q, d1_vld_d, d2_vld_q, d2_vld_d;

  state_t        state_q, state_d;

  // output stage
  logic          o_fval_q, o_fval_d, o_lval_q, o_lval_d, o_frame_done_q, o_frame_done_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [CNT_WIDTH-1:0] width_q, width_d, height_q, height_d;
  logic          line_err_q, line_err_d;

  // per-frame measurement
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0] cur_len_q, cur_len_d, ref_len_q, ref_len_d;
  logic          ref_vld_q, ref_vld_d, err_acc_q, err_acc_d;

  logic rise, fall, lv, pass, lv_pass, line_end;

  always_comb begin
    rise     = d1_fval_q & ~d2_fval_q & d2_vld_q;
    fall     = ~d1_fval_q & d2_fval_q & d2_vld_q;
    lv       = d1_lval_q & d1_fval_q;
    // a frame may start passing on its very first cycle, keeping latency constant
    pass     = (state_q == ST_ON) | (i_stream_enable & rise);
    lv_pass  = lv & pass;
    // o_lval_q is the previous lv&pass, so this also catches lval still high when fval falls
    line_end = pass & o_lval_q & ~lv_pass;

    d1_fval_d = i_fval;
    d1_lval_d = i_lval;
    d1_data_d = iv_pix_data;
    d2_fval_d = d1_fval_q;
    d1_vld_d  = 1'b1;
    d2_vld_d  = d1_vld_q;

    state_d = state_q;
    if (state_q == ST_OFF && i_stream_enable && rise) state_d = ST_ON;
    if (state_q == ST_ON && fall && !i_stream_enable) state_d = ST_OFF;

    o_fval_d = d1_fval_q & pass;
    o_lval_d = lv_pass;
    pix_d    = lv_pass ? d1_data_q : '0;

    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    cur_len_d  = cur_len_q;
    ref_len_d  = ref_len_q;
    ref_vld_d  = ref_vld_q;
    err_acc_d  = err_acc_q;

    if (pass) begin
      if (rise) begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        cur_len_d  = '0;
        ref_vld_d  = 1'b0;
        err_acc_d  = 1'b0;
      end
      if (lv) begin
        pix_cnt_d = sat_inc(pix_cnt_d);
      end else if (line_end) begin
        cur_len_d  = pix_cnt_d;
        line_cnt_d = sat_inc(line_cnt_d);
        pix_cnt_d  = '0;
        if (!ref_vld_d) begin
          ref_len_d = cur_len_d;
          ref_vld_d = 1'b1;
        end else if (cur_len_d != ref_len_d) begin
          err_acc_d = 1'b1;
        end
      end
    end

    // stats use the post-update values so a line ending on the fall cycle is included
    o_frame_done_d = fall & (state_q == ST_ON);
    width_d    = width_q;
    height_d   = height_q;
    line_err_d = line_err_q;
    if (o_frame_done_d) begin
      width_d    = cur_len_d;
      height_d   = line_cnt_d;
      line_err_d = err_acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1_fval_q      <= 1'b0;
      d1_lval_q      <= 1'b0;
      d1_data_q      <= '0;
      d2_fval_q      <= 1'b0;
      d1_vld_q       <= 1'b0;
      d2_vld_q       <= 1'b0;
      state_q        <= ST_OFF;
      o_fval_q       <= 1'b0;
      o_lval_q       <= 1'b0;
      pix_q          <= '0;
      o_frame_done_q <= 1'b0;
      width_q        <= '0;
      height_q       <= '0;
      line_err_q     <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      cur_len_q      <= '0;
      ref_len_q      <= '0;
      ref_vld_q      <= 1'b0;
      err_acc_q      <= 1'b0;
    end else begin
      d1_fval_q      <= d1_fval_d;
      d1_lval_q      <= d1_lval_d;
      d1_data_q      <= d1_data_d;
      d2_fval_q      <= d2_fval_d;
      d1_vld_q       <= d1_vld_d;
      d2_vld_q       <= d2_vld_d;
      state_q        <= state_d;
      o_fval_q       <= o_fval_d;
      o_lval_q       <= o_lval_d;
      pix_q          <= pix_d;
      o_frame_done_q <= o_frame_done_d;
      width_q        <= width_d;
      height_q       <= height_d;
      line_err_q     <= line_err_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      cur_len_q      <= cur_len_d;
      ref_len_q      <= ref_len_d;
      ref_vld_q      <= ref_vld_d;
      err_acc_q      <= err_acc_d;
    end
  end

  assign o_fval          = o_fval_q;
  assign o_lval          = o_lval_q;
  assign ov_pix_data     = pix_q;
  assign o_frame_done    = o_frame_done_q;
  assign ov_frame_width  = width_q;
  assign ov_frame_height = height_q;
  assign o_line_err      = line_err_q;

endmodule

// File: tb/tb_stream_frame_gate.sv
// Purpose : directed bench for stream_frame_gate; output stream compared cycle by cycle
//           against the input delayed 2 clk (or zero for blocked frames), frame stats per frame.
// Clocking: inputs driven and outputs sampled on the falling edge.
module tb_stream_frame_gate;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_stream_enable = 1'b0;
  logic        i_fval = 1'b0;
  logic        i_lval = 1'b0;
  logic [11:0] iv_pix_data = '0;
  logic        o_fval, o_lval, o_frame_done, o_line_err;
  logic [11:0] ov_pix_data;
  logic [15:0] ov_frame_width, ov_frame_height;

  stream_frame_gate #(.DATA_WIDTH(12), .CHANNEL_NUM(1), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_stream_enable (i_stream_enable),
    .i_fval          (i_fval),
    .i_lval          (i_lval),
    .iv_pix_data     (iv_pix_data),
    .o_fval          (o_fval),
    .o_lval          (o_lval),
    .ov_pix_data     (ov_pix_data),
    .o_frame_done    (o_frame_done),
    .ov_frame_width  (ov_frame_width),
    .ov_frame_height (ov_frame_height),
    .o_line_err      (o_line_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];      // expected {o_fval, o_lval, ov_pix_data}, 2-cycle delay line
  bit          gate = 1'b0;   // current frame is expected to pass
  bit          rst_seen = 1'b0;
  logic        prev_fval = 1'b0;
  int          done_cnt = 0;
  int          dw_q[$];
  int          dh_q[$];
  int          cyc_i = 0;
  int          en_at_v = -1;
  bit          en_new_v = 1'b0;
  int          rst_at_v = -1;
  logic [11:0] pix_val = 12'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit f, input bit l, input logic [11:0] d, input bit rn);
    logic [13:0] e;
    @(negedge clk);
    if (rst_seen) begin
      chk("rst_outputs", {o_frame_done, o_line_err, ov_frame_width, ov_frame_height}, 32'h0);
      rst_seen = 1'b0;
    end
    if (o_frame_done === 1'b1) begin
      chk("done_on_fval_drop", {prev_fval, o_fval}, 32'h2);
      done_cnt++;
      dw_q.push_back(int'(ov_frame_width));
      dh_q.push_back(int'(ov_frame_height));
    end
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      chk("stream", {o_fval, o_lval, ov_pix_data}, {18'h0, e});
    end
    prev_fval = o_fval;
    i_fval = f;
    i_lval = l;
    iv_pix_data = d;
    reset_n = rn;
    if (!rn) begin
      foreach (exp_q[i]) exp_q[i] = '0;
      exp_q.push_back('0);
      rst_seen = 1'b1;
    end else begin
      exp_q.push_back(gate ? {f, f & l, (f & l) ? d : 12'h0} : 14'h0);
    end
  endtask

  task automatic tick(input bit f, input bit l);
    bit rn;
    rn = 1'b1;
    if (cyc_i == en_at_v) i_stream_enable = en_new_v;
    if (cyc_i == rst_at_v) begin
      rn = 1'b0;
      gate = 1'b0;
    end
    drive(f, l, pix_val, rn);
    pix_val++;
    cyc_i++;
  endtask

  // one frame: 1-cycle porch, nl lines (line sh_idx has sh_w pixels), line hide 3,
  // one lval-low cycle before fall unless hang, then fh cycles of fval low
  task automatic frame(input int nl, input int w, input int sh_idx, input int sh_w,
                       input int fh, input bit hang, input bit g);
    gate = g;
    cyc_i = 0;
    tick(1'b1, 1'b0);
    for (int ln = 0; ln < nl; ln++) begin
      int len;
      len = (ln == sh_idx) ? sh_w : w;
      for (int p = 0; p < len; p++) tick(1'b1, 1'b1);
      if (ln < nl - 1) begin
        for (int h = 0; h < 3; h++) tick(1'b1, 1'b0);
      end else if (!hang) begin
        tick(1'b1, 1'b0);
      end
    end
    for (int h = 0; h < fh; h++) tick(1'b0, 1'b0);
    en_at_v = -1;
    rst_at_v = -1;
  endtask

  task automatic exp_frames(input string tag, input int nd, input int w, input int h, input int e);
    chk({tag, "_done_cnt"}, done_cnt, nd);
    chk({tag, "_width"}, ov_frame_width, w);
    chk({tag, "_height"}, ov_frame_height, h);
    chk({tag, "_line_err"}, o_line_err, e);
    done_cnt = 0;
    dw_q.delete();
    dh_q.delete();
  endtask

  initial begin
    // reset for 3 cycles, then idle with enable on
    repeat (3) drive(1'b0, 1'b0, 12'h0, 1'b0);
    i_stream_enable = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 12'h0, 1'b1);
    chk("reset_done_cnt", done_cnt, 0);

    // clean 8x4 frame passes unchanged
    frame(4, 8, -1, 0, 10, 1'b0, 1'b1);
    exp_frames("f1_clean", 1, 8, 4, 0);

    // line 3 short by one pixel
    frame(4, 8, 2, 7, 10, 1'b0, 1'b1);
    exp_frames("f2_short", 1, 8, 4, 1);

    // next clean frame clears the error, new geometry
    frame(2, 6, -1, 0, 10, 1'b0, 1'b1);
    exp_frames("f3_clear", 1, 6, 2, 0);

    // enable dropped in line 1: frame still completes
    en_at_v = 3; en_new_v = 1'b0;
    frame(4, 8, -1, 0, 10, 1'b0, 1'b1);
    exp_frames("f4_drop", 1, 8, 4, 0);

    // following frames blocked, stats hold
    frame(3, 5, -1, 0, 10, 1'b0, 1'b0);
    frame(3, 5, -1, 0, 10, 1'b0, 1'b0);
    exp_frames("f56_blocked", 0, 8, 4, 0);

    // enable raised during line 2: that frame blocked entirely
    en_at_v = 11; en_new_v = 1'b1;
    frame(3, 5, -1, 0, 10, 1'b0, 1'b0);
    exp_frames("f7_late_en", 0, 8, 4, 0);

    // next frame passes complete
    frame(4, 8, -1, 0, 10, 1'b0, 1'b1);
    exp_frames("f8_after_en", 1, 8, 4, 0);

    // stray lval outside fval, and lval high on the last fval cycle
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    frame(3, 7, -1, 0, 2, 1'b1, 1'b1);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    exp_frames("f9_hang", 1, 7, 3, 0);

    // 1-clk reset mid line 2: rest of frame discarded, stats cleared
    rst_at_v = 14;
    frame(4, 8, -1, 0, 10, 1'b0, 1'b1);
    exp_frames("f10_rst", 0, 0, 0, 0);

    // back-to-back frames with a single-cycle fval gap
    frame(4, 8, -1, 0, 1, 1'b0, 1'b1);
    frame(2, 5, -1, 0, 10, 1'b0, 1'b1);
    chk("f11_done_entries", dw_q.size(), 2);
    if (dw_q.size() == 2) begin
      chk("f11_width", dw_q[0], 8);
      chk("f11_height", dh_q[0], 4);
      chk("f12_width_at_done", dw_q[1], 5);
      chk("f12_height_at_done", dh_q[1], 2);
    end
    exp_frames("f12_gap", 2, 5, 2, 0);

    repeat (3) tick(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
